// File: rtl/if_types_pkg.sv
// Shared interface state types for the OBI master slice.
// Holds the client-side interface enum and the OBI master FSM enum.
package if_types_pkg;

    typedef enum logic [1:0] {
        IF_IDLE   = 2'd0,
        IF_ACTIVE = 2'd1,
        IF_DONE   = 2'd2
    } if_state_e;

    typedef enum logic [1:0] {
        M_IDLE     = 2'd0,
        M_REQ      = 2'd1,
        M_WAIT_RSP = 2'd2,
        M_RESP     = 2'd3
    } if_master_state_e;

    localparam int unsigned WAIT_CTR_W = 16;

endpackage

// File: rtl/obi_timeout_ctr.sv
// Saturating wait-cycle counter; expired_o flags the cycle whose count equals the limit.
// Clear has priority so the first cycle of a wait phase always reads zero.
module obi_timeout_ctr
    import if_types_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic [WAIT_CTR_W-1:0] limit_i,
    output logic                  expired_o
);

    logic [WAIT_CTR_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && (count_q == limit_i);

endmodule

// File: rtl/obi_cache_master.sv
// Single-outstanding OBI master: takes one client command, issues it on OBI,
// and returns read data or a timeout error to the client.
//
// state      | meaning
// M_IDLE     | ready for a client command
// M_REQ      | obi_req_o asserted, waiting for grant
// M_WAIT_RSP | granted, waiting for obi_rvalid_i
// M_RESP     | response presented to client until rsp_ready_i
module obi_cache_master
    import if_types_pkg::*;
#(
    parameter int ARCHITECTURE   = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_write_i,
    input  logic [ARCHITECTURE-1:0]   cmd_key_i,
    input  logic [2*ARCHITECTURE-1:0] cmd_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [2*ARCHITECTURE-1:0] rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      obi_req_o,
    output logic [ARCHITECTURE-1:0]   obi_addr_o,
    output logic                      obi_we_o,
    output logic [2*ARCHITECTURE-1:0] obi_wdata_o,
    input  logic                      obi_gnt_i,
    input  logic                      obi_rvalid_i,
    input  logic [2*ARCHITECTURE-1:0] obi_rdata_i,
    output logic                      obi_rready_o
);

    localparam int KEY   = ARCHITECTURE;
    localparam int VALUE = 2 * ARCHITECTURE;

    if_master_state_e state_q, state_d;
    logic [KEY-1:0]   addr_q, addr_d;
    logic [VALUE-1:0] wdata_q, wdata_d;
    logic [VALUE-1:0] rdata_q, rdata_d;
    logic             we_q, we_d;
    logic             err_q, err_d;
    logic             ctr_clear;
    logic             ctr_enable;
    logic             expired;

    assign ctr_enable = (state_q == M_REQ) || (state_q == M_WAIT_RSP);

    obi_timeout_ctr u_timeout_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (ctr_clear),
        .enable_i  (ctr_enable),
        .limit_i   (WAIT_CTR_W'(TIMEOUT_CYCLES)),
        .expired_o (expired)
    );

    // Handshakes are checked before the timeout so a late gnt/rvalid still completes.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        ctr_clear = 1'b0;
        case (state_q)
            M_IDLE: begin
                if (cmd_valid_i) begin
                    addr_d    = cmd_key_i;
                    wdata_d   = cmd_wdata_i;
                    we_d      = cmd_write_i;
                    ctr_clear = 1'b1;
                    state_d   = M_REQ;
                end
            end
            M_REQ: begin
                if (obi_gnt_i) begin
                    ctr_clear = 1'b1;
                    state_d   = M_WAIT_RSP;
                end else if (expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = M_RESP;
                end
            end
            M_WAIT_RSP: begin
                if (obi_rvalid_i) begin
                    rdata_d = we_q ? '0 : obi_rdata_i;
                    err_d   = 1'b0;
                    state_d = M_RESP;
                end else if (expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = M_RESP;
                end
            end
            M_RESP: begin
                if (rsp_ready_i) begin
                    state_d = M_IDLE;
                end
            end
            default: begin
                state_d = M_IDLE;
                addr_d  = '0;
                wdata_d = '0;
                we_d    = 1'b0;
                rdata_d = '0;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= M_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Handshake outputs decode straight from state so reset drops them asynchronously.
    assign cmd_ready_o  = (state_q == M_IDLE);
    assign obi_req_o    = (state_q == M_REQ);
    assign obi_rready_o = (state_q == M_WAIT_RSP);
    assign rsp_valid_o  = (state_q == M_RESP);
    assign obi_addr_o   = addr_q;
    assign obi_we_o     = we_q;
    assign obi_wdata_o  = wdata_q;
    assign rsp_rdata_o  = rdata_q;
    assign rsp_err_o    = err_q;

endmodule

// File: doc/obi_cache_master.md
OBI_CACHE_MASTER -- requirements
Module: obi_cache_master

Interface
REQ-001 Parameter ARCHITECTURE SHALL be: default 64; bits per register.
REQ-002 Parameter TIMEOUT_CYCLES SHALL be: default 255; maximum wait cycles per phase (1..65535).
REQ-003 Port clk SHALL be: input, 1 bit; single clock, rising edge.
REQ-004 Port rst_n SHALL be: input, 1 bit; reset, asynchronous, active-low.
REQ-005 Client ports SHALL be: cmd_valid_i in 1; cmd_ready_o out 1; cmd_write_i in 1; cmd_key_i in ARCHITECTURE; cmd_wdata_i in 2*ARCHITECTURE.
REQ-006 Client response ports SHALL be: rsp_valid_o out 1; rsp_ready_i in 1; rsp_rdata_o out 2*ARCHITECTURE; rsp_err_o out 1 (timeout).
REQ-007 OBI request ports SHALL be: obi_req_o out 1; obi_addr_o out ARCHITECTURE (key); obi_we_o out 1; obi_wdata_o out 2*ARCHITECTURE; obi_gnt_i in 1.
REQ-008 OBI response ports SHALL be: obi_rvalid_i in 1; obi_rdata_i in 2*ARCHITECTURE; obi_rready_o out 1.

Function
REQ-009 The FSM SHALL have four states: M_IDLE, M_REQ, M_WAIT_RSP, M_RESP.
REQ-010 In M_IDLE, cmd_ready_o SHALL be 1 (combinational); in all other states 0; at most one transaction outstanding.
REQ-011 On cmd_valid_i && cmd_ready_o, the block SHALL register key, wdata, write into addr/wdata/we registers and go to M_REQ.
REQ-012 In M_REQ, obi_req_o SHALL be 1 with obi_addr_o/obi_we_o/obi_wdata_o driven from registers and held stable until grant.
REQ-013 In M_REQ, obi_gnt_i=1 SHALL move to M_WAIT_RSP; obi_req_o SHALL be 0 the following cycle.
REQ-014 obi_rvalid_i SHALL be ignored outside M_WAIT_RSP.
REQ-015 In M_WAIT_RSP, obi_rready_o SHALL be 1; elsewhere 0.
REQ-016 In M_WAIT_RSP, obi_rvalid_i=1 SHALL capture rsp_rdata (obi_rdata_i for reads, 0 for writes), clear rsp_err, go to M_RESP.
REQ-017 In M_RESP, rsp_valid_o SHALL be 1; rsp_rdata_o/rsp_err_o held stable; rsp_ready_i=1 SHALL return to M_IDLE.
REQ-018 rsp_valid_o SHALL NOT depend combinationally on rsp_ready_i; back-to-back cmd acceptance starts earliest the cycle after response handshake.
REQ-019 Latency: cmd accepted cycle N -> obi_req_o cycle N+1; gnt at N+1 and rvalid at N+2 -> rsp_valid_o at N+3.
REQ-020 A 16-bit wait counter SHALL clear on entry to M_REQ and M_WAIT_RSP and increment each cycle in those states, saturating.
REQ-021 When the counter equals TIMEOUT_CYCLES in M_REQ (no gnt) or M_WAIT_RSP (no rvalid), the FSM SHALL go to M_RESP with rsp_err_o=1, rsp_rdata_o=0, and drop obi_req_o/obi_rready_o.
REQ-022 gnt or rvalid arriving in the same cycle as the timeout compare SHALL take precedence over the timeout.
REQ-023 Unreachable state encodings SHALL return to M_IDLE with all outputs at reset values.

Reset
REQ-024 On rst_n=0, state SHALL be M_IDLE, counter 0, all registers and outputs 0 except cmd_ready_o=1.
REQ-025 Reset mid-transaction SHALL abort immediately with no response issued and obi_req_o=0 in the same cycle reset asserts.

Structure
REQ-026 The state enum if_master_state_e SHALL live in if_types_pkg alongside the existing interface state enum.
REQ-027 Key/value width localparams SHALL derive from ARCHITECTURE (KEY=ARCHITECTURE, VALUE=2*ARCHITECTURE) in module.
REQ-028 The wait counter SHALL be a sub-module obi_timeout_ctr (clear, enable, limit in; expired out).

Verification
REQ-029 Read: cmd key=0x10, write=0; gnt same cycle as req; rvalid next cycle with rdata=0xDEADBEEF -> rsp_valid at N+3, rdata=0xDEADBEEF, err=0.
REQ-030 Write: key=0x20, wdata=0x1234; gnt delayed 3 cycles -> obi_req_o high 4 cycles with addr=0x20, we=1, wdata stable; rsp rdata=0.
REQ-031 Grant timeout: TIMEOUT_CYCLES=4, gnt held 0 -> rsp_valid with err=1 after 4 wait cycles, obi_req_o drops.
REQ-032 Response backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and rdata stable, cmd_ready_o 0 throughout.
REQ-033 Reset during M_WAIT_RSP -> all outputs to reset values immediately; late rvalid after reset ignored, no rsp_valid.
REQ-034 gnt at exact timeout cycle -> transaction proceeds normally, err=0.
